fib_shared_engine_arbiter: RTL and testbench

- Round-robin arbiter plus sequencer that shares one iterative Fibonacci datapath between two requesters.
- Each requester asks for F(n) over a valid/ready handshake. The block grants one request and steps the two-register datapath n times. It returns F(n) with the requester ID and an overflow flag over a valid/ready response channel.
- Sits between client logic and the Fibonacci datapath; no other block drives that datapath.

---
 rtl/fib_shared_engine_arbiter.sv | 123 ++++++++++++
 tb/tb_fib_shared_engine_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_shared_engine_arbiter.sv
// Round-robin arbiter sharing one iterative Fibonacci datapath
// between two requesters, with a registered response channel.
module fib_shared_engine_arbiter #(
  parameter int W  = 16,
  parameter int NW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [NW-1:0] req0_n,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [NW-1:0] req1_n,
  output logic          req1_ready,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_id,
  output logic [W-1:0]  resp_num,
  output logic          resp_ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESPOND
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ovf_a;
  logic          ovf_b;
  logic [NW-1:0] cnt;
  logic          id;
  logic          prefer;
  logic          resp_q;
  logic          win1;
  logic          take;
  logic [W:0]    sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // Pick the winner among valid requesters; ties go to the preferred one.
  always_comb begin
    win1       = req1_valid & (~req0_valid | prefer);
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE && !rst) begin
      req0_ready = req0_valid & ~win1;
      req1_ready = win1;
    end
    take = req0_ready | req1_ready;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = COMPUTE;
      COMPUTE: if (cnt == '0) state_nx = RESPOND;
      RESPOND: if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered response-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      resp_q <= 1'b0;
    end else begin
      state  <= state_nx;
      resp_q <= (state_nx == RESPOND);
    end
  end

  // Datapath: load on grant, step the recurrence once per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a      <= '0;
      b      <= '0;
      ovf_a  <= 1'b0;
      ovf_b  <= 1'b0;
      cnt    <= '0;
      id     <= 1'b0;
      prefer <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            id     <= win1;
            a      <= '0;
            b      <= {{(W-1){1'b0}}, 1'b1};
            ovf_a  <= 1'b0;
            ovf_b  <= 1'b0;
            cnt    <= win1 ? req1_n : req0_n;
            prefer <= ~win1;
          end
        end
        COMPUTE: begin
          if (cnt != '0) begin
            a     <= b;
            b     <= sum[W-1:0];
            ovf_a <= ovf_b;
            ovf_b <= ovf_a | ovf_b | sum[W];
            cnt   <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = resp_q;
  assign resp_id    = id;
  assign resp_num   = a;
  assign resp_ovf   = ovf_a;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fib_shared_engine_arbiter.sv
// Self-checking bench: vector table, hand sequences and a
// randomized run against a plain-arithmetic Fibonacci model.
module tb_fib_shared_engine_arbiter;

  localparam int W  = 16;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid;
  logic [NW-1:0] req0_n;
  logic          req0_ready;
  logic          req1_valid;
  logic [NW-1:0] req1_n;
  logic          req1_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_id;
  logic [W-1:0]  resp_num;
  logic          resp_ovf;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fib_shared_engine_arbiter #(.W(W), .NW(NW)) dut (
    .clk(clk),
    .rst(rst),
    .req0_valid(req0_valid),
    .req0_n(req0_n),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_n(req1_n),
    .req1_ready(req1_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id(resp_id),
    .resp_num(resp_num),
    .resp_ovf(resp_ovf),
    .busy(busy)
  );

  typedef struct {
    logic       id;
    int         n;
    int         stall;
    logic [W-1:0] num;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact Fibonacci in 64 bits, reduced afterwards.
  function automatic longint fib(input int n);
    longint x = 0;
    longint y = 1;
    longint t;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_outputs",
        {resp_valid, resp_id, resp_ovf, busy, req0_ready,
         req1_ready, resp_num}, 0);
  endtask

  // One full transaction from a single requester.
  task automatic run_req(input string tag, input logic rid,
                         input int n, input int stall,
                         input logic [W-1:0] exp_num,
                         input logic exp_ovf);
    int lat;
    int busy_bad;
    int stab_bad;
    int rdy_bad;
    logic got;
    logic [W-1:0] n0;
    logic id0;
    logic ov0;
    @(negedge clk);
    if (rid) begin
      req1_valid = 1'b1;
      req1_n = NW'(n);
    end else begin
      req0_valid = 1'b1;
      req0_n = NW'(n);
    end
    resp_ready = 1'b0;
    #1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((rid ? req1_ready : req0_ready) &&
          !(rid ? req0_ready : req1_ready)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk({tag, "_grant"}, got, 1);
    if (!got) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    busy_bad = 0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_n = NW'($urandom);
        req1_n = NW'($urandom);
      end
      #1;
      if (!busy) busy_bad++;
      if (resp_valid) begin
        got = 1'b1;
        lat = i;
        break;
      end
    end
    chk({tag, "_resp_seen"}, got, 1);
    if (!got) return;
    chk({tag, "_latency"}, lat, n + 2);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_num"}, resp_num, exp_num);
    chk({tag, "_ovf"}, resp_ovf, exp_ovf);
    chk({tag, "_id"}, resp_id, rid);
    n0 = resp_num;
    id0 = resp_id;
    ov0 = resp_ovf;
    stab_bad = 0;
    rdy_bad = 0;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) resp_ready = 1'b1;
      if (stall > 0) begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
      end
      #1;
      if (!resp_valid || resp_num != n0 || resp_id != id0 ||
          resp_ovf != ov0) stab_bad++;
      if (req0_ready || req1_ready) rdy_bad++;
      if (i < stall) begin
        @(negedge clk);
        #1;
      end
    end
    @(negedge clk);
    resp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    if (stall > 0) begin
      chk({tag, "_stable"}, stab_bad, 0);
      chk({tag, "_no_ready"}, rdy_bad, 0);
    end
    chk({tag, "_idle_after"}, {busy, resp_valid}, 0);
  endtask

  vec_t vt[7];
  int grants[$];
  int bad;
  int seen;
  int rn;
  logic rid;
  longint f;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_n = '0;
    req1_n = '0;
    resp_ready = 1'b0;

    vt[0] = '{id: 1'b0, n: 10, stall: 0, num: 16'd55,    ovf: 1'b0};
    vt[1] = '{id: 1'b1, n: 0,  stall: 0, num: 16'd0,     ovf: 1'b0};
    vt[2] = '{id: 1'b1, n: 1,  stall: 0, num: 16'd1,     ovf: 1'b0};
    vt[3] = '{id: 1'b0, n: 24, stall: 0, num: 16'd46368, ovf: 1'b0};
    vt[4] = '{id: 1'b1, n: 25, stall: 1, num: 16'd9489,  ovf: 1'b1};
    vt[5] = '{id: 1'b0, n: 30, stall: 0, num: 16'd45608, ovf: 1'b1};
    vt[6] = '{id: 1'b0, n: 5,  stall: 6, num: 16'd5,     ovf: 1'b0};

    do_reset();
    foreach (vt[i])
      run_req($sformatf("vec%0d", i), vt[i].id, vt[i].n,
              vt[i].stall, vt[i].num, vt[i].ovf);

    // Both requesters continuously valid: grants must alternate.
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_n = 6'd3;
    req1_n = 6'd3;
    resp_ready = 1'b1;
    bad = 0;
    seen = 0;
    for (int i = 0; i < 200 && grants.size() < 4; i++) begin
      #1;
      if (req0_ready && req1_ready) bad++;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (resp_valid) begin
        seen++;
        if (resp_num != 16'd2) bad++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("alt_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++)
      chk($sformatf("alt_grant%0d", i), grants[i], i % 2);
    chk("alt_bad", bad, 0);
    chk("alt_resps", seen >= 3, 1);
    for (int i = 0; i < 10; i++) @(negedge clk);

    // Reset in the middle of a computation abandons it.
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1;
    req0_n = 6'd20;
    @(negedge clk);
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", {busy, resp_valid}, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid || busy) seen++;
    end
    chk("mid_rst_quiet", seen, 0);
    @(negedge clk);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_n = 6'd7;
    req1_n = 6'd9;
    #1;
    chk("post_rst_pref0", {req0_ready, req1_ready}, 2'b10);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (resp_valid) begin
        seen = 1;
        chk("post_rst_num", resp_num, 13);
        chk("post_rst_id", resp_id, 0);
      end
      @(negedge clk);
    end
    chk("post_rst_resp", seen, 1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Randomized single-requester transactions vs. the model.
    do_reset();
    for (int k = 0; k < 25; k++) begin
      rid = 1'($urandom);
      rn = int'($urandom_range(0, 40));
      f = fib(rn);
      run_req($sformatf("rnd%0d", k), rid, rn,
              int'($urandom_range(0, 3)),
              f[W-1:0], f >= (64'd1 << W));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
